// File: rtl/circuit_vector_driver.sv
// Exhaustive driver/checker for a 3-input, 1-output combinational circuit under test.
// Steps {a,b,c} through all 8 vectors, samples the response after a settle time, and compares it to EXPECTED.
module circuit_vector_driver #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'hE2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       o_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] truth_table,
  output logic [3:0] mismatch_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] tt_q, tt_d;
  logic [3:0] mm_q, mm_d;
  logic       miss;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tt_q    <= 8'h00;
      mm_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tt_q    <= tt_d;
      mm_q    <= mm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    tt_d    = tt_q;
    mm_d    = mm_q;
    miss    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETTLE;
          idx_d   = 3'd0;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          tt_d    = 8'h00;
          mm_d    = 4'd0;
        end
      end
      SETTLE: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               state_d = SAMPLE;
      end
      SAMPLE: begin
        tt_d[idx_q] = o_in;
        miss        = (o_in != EXPECTED[idx_q]);
        mm_d        = mm_q + {3'b000, miss};
        if (idx_q == 3'd7) begin
          // pass is taken from the final count so it is valid in the first done cycle
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (mm_d == 4'd0);
        end else begin
          state_d = SETTLE;
          idx_d   = idx_q + 3'd1;
          cnt_d   = CNT_INIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The vector index register drives the CUT directly; it rests at 3'b111 in DONE.
  assign {a, b, c}    = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign truth_table  = tt_q;
  assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_circuit_vector_driver.sv
// Directed bench for circuit_vector_driver: a delayed circuit_2 model, a result scoreboard and timing checks.
// DUT 1 uses the default settle time; DUT 2 uses SETTLE_CYCLES=1 on a clock whose period can be changed.
module tb_circuit_vector_driver;

  typedef struct {
    logic [7:0] tt;
    logic [3:0] mm;
    logic       pass;
  } exp_t;

  logic clk1 = 1'b0;
  logic clk2 = 1'b0;
  int   hp2  = 10;
  logic rst   = 1'b1;
  logic start = 1'b0;
  bit   sel   = 1'b0;
  int   mode  = 0;

  logic a1, b1, c1, busy1, done1, pass1;
  logic a2, b2, c2, busy2, done2, pass2;
  logic [7:0] tt1, tt2;
  logic [3:0] mm1, mm2;
  wire  cut1, cut2;
  logic o_in1, start1, start2;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  initial forever #5 clk1 = ~clk1;
  initial forever #(hp2) clk2 = ~clk2;

  // circuit_2 behaviour: o = ab + ac + a'b'c, with a 20-unit worst-case delay
  assign #20 cut1 = (a1 & b1) | (a1 & c1) | (~a1 & ~b1 & c1);
  assign #20 cut2 = (a2 & b2) | (a2 & c2) | (~a2 & ~b2 & c2);

  assign o_in1  = (mode == 0) ? cut1 : (mode == 1) ? 1'b0 : 1'b1;
  assign start1 = start & ~sel;
  assign start2 = start & sel;

  circuit_vector_driver dut1 (
    .clk(clk1), .rst(rst), .start(start1), .o_in(o_in1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .truth_table(tt1), .mismatch_cnt(mm1)
  );

  circuit_vector_driver #(.SETTLE_CYCLES(1), .EXPECTED(8'hE2)) dut2 (
    .clk(clk2), .rst(rst), .start(start2), .o_in(cut2),
    .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
    .truth_table(tt2), .mismatch_cnt(mm2)
  );

  logic [2:0] vec_s;
  logic       busy_s, done_s, pass_s;
  logic [7:0] tt_s;
  logic [3:0] mm_s;
  assign vec_s  = sel ? {a2, b2, c2} : {a1, b1, c1};
  assign busy_s = sel ? busy2 : busy1;
  assign done_s = sel ? done2 : done1;
  assign pass_s = sel ? pass2 : pass1;
  assign tt_s   = sel ? tt2 : tt1;
  assign mm_s   = sel ? mm2 : mm1;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) @(posedge clk2);
      else     @(posedge clk1);
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vec"}, 32'(vec_s), 0);
    chk({tag, "_busy"}, 32'(busy_s), 0);
    chk({tag, "_done"}, 32'(done_s), 0);
    chk({tag, "_pass"}, 32'(pass_s), 0);
    chk({tag, "_tt"}, 32'(tt_s), 0);
    chk({tag, "_mm"}, 32'(mm_s), 0);
  endtask

  // Push the expected result, issue start, and check the cleared state in the first busy cycle.
  task automatic start_sweep(input logic [7:0] tt, input logic [3:0] mm, input bit hold);
    exp_t e;
    e.tt = tt; e.mm = mm; e.pass = (mm == 4'd0);
    sb.push_back(e);
    start = 1'b1;
    tick(1);
    if (!hold) start = 1'b0;
    chk("start_busy", 32'(busy_s), 1);
    chk("start_done", 32'(done_s), 0);
    chk("start_vec", 32'(vec_s), 0);
    chk("clr_tt", 32'(tt_s), 0);
    chk("clr_mm", 32'(mm_s), 0);
  endtask

  // j counts cycles after the start edge; done is due in cycle 8*(S+1)+1.
  task automatic wait_done(input int j0, input bit chk_seq);
    int   j   = j0;
    int   per = sel ? 2 : 5;
    int   lat = sel ? 17 : 41;
    exp_t e;
    while (done_s !== 1'b1 && j < 200) begin
      if (chk_seq) begin
        chk($sformatf("vec_c%0d", j), 32'(vec_s), (j - 1) / per);
        chk($sformatf("busy_c%0d", j), 32'(busy_s), 1);
      end
      tick(1);
      j++;
    end
    chk("latency", j, lat);
    chk("sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("truth_table", 32'(tt_s), 32'(e.tt));
      chk("mismatch_cnt", 32'(mm_s), 32'(e.mm));
      chk("pass", 32'(pass_s), 32'(e.pass));
    end
    chk("done_busy", 32'(busy_s), 0);
    chk("done_vec", 32'(vec_s), 7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int j;
    // reset and a nominal sweep with full vector/busy tracking
    rst = 1'b1;
    tick(2);
    sel = 1'b1; tick(2); sel = 1'b0;
    rst = 1'b0;
    chk_reset("rst1");
    start_sweep(8'hE2, 4'd0, 1'b0);
    wait_done(1, 1'b1);

    // constant CUT responses; counters must clear on restart
    mode = 1;
    start_sweep(8'h00, 4'd4, 1'b0);
    wait_done(1, 1'b0);
    mode = 2;
    start_sweep(8'hFF, 4'd4, 1'b0);
    wait_done(1, 1'b0);
    mode = 0;

    // start pulse during vector 3 is ignored
    start_sweep(8'hE2, 4'd0, 1'b0);
    tick(16);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(18, 1'b1);

    // start held high: one-cycle done, then back-to-back sweeps
    start_sweep(8'hE2, 4'd0, 1'b1);
    wait_done(1, 1'b1);
    start_sweep(8'hE2, 4'd0, 1'b1);
    start = 1'b0;
    wait_done(1, 1'b0);

    // reset during SETTLE of vector 5 aborts without a done
    start_sweep(8'hE2, 4'd0, 1'b0);
    tick(26);
    chk("pre_abort_vec", 32'(vec_s), 5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    void'(sb.pop_back());
    chk_reset("abort");
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (done_s !== 1'b0) seen = 1'b1;
    end
    chk("no_done_after_abort", 32'(seen), 0);
    start_sweep(8'hE2, 4'd0, 1'b0);
    wait_done(1, 1'b0);

    // SETTLE_CYCLES=1 with a slow clock settles correctly
    sel = 1'b1;
    tick(1);
    start_sweep(8'hE2, 4'd0, 1'b0);
    wait_done(1, 1'b1);

    // with a fast clock the CUT cannot settle and mismatches appear
    hp2 = 2;
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    j = 1;
    while (done_s !== 1'b1 && j < 200) begin
      tick(1);
      j++;
    end
    chk("fast_latency", j, 17);
    chk("fast_mm_nonzero", 32'(mm_s != 4'd0), 1);
    chk("fast_pass", 32'(pass_s), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
